fifo_sc_prog: RTL and testbench

- Parametrised single-clock FIFO. Successor to the team's register-array FIFO.
- Adds programmable almost-full and almost-empty thresholds, a full-range occupancy count, sticky overflow/underflow error flags, and a selectable read mode: first-word-fall-through or registered output.
- Sits between a CPU-side producer and a datapath consumer in the same clock domain.

---
 rtl/fifo_sc_prog.sv | 111 +++++++++++
 tb/tb_fifo_sc_prog.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_sc_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty levels and sticky error flags.
// Selectable read path: first-word-fall-through (FWFT=1) or registered output (FWFT=0).
module fifo_sc_prog #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 4,
    parameter bit FWFT       = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wen,
    input  logic                  ren,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] FULL_LVL = CW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_LVL   = CW'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_LVL   = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wenAcc, renAcc;

    // Flags look only at the registered count, so they never react combinationally to wen/ren.
    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_LVL);
    assign almost_empty = (count_q <= AE_LVL);
    assign almost_full  = (count_q >= AF_LVL);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wenAcc = wen & ~full;
    assign renAcc = ren & ~empty;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (wenAcc) wrPtr_d = wrPtr_q + 1'b1;
        if (renAcc) rdPtr_d = rdPtr_q + 1'b1;
        case ({wenAcc, renAcc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Setting takes priority over a simultaneous clr_err.
        overflow_d  = (overflow_q  & ~clr_err) | (wen & full);
        underflow_d = (underflow_q & ~clr_err) | (ren & empty);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wenAcc) mem_q[wrPtr_q] <= data_in;
    end

    if (FWFT) begin : gFwft
        assign data_out = mem_q[rdPtr_q];
        assign rd_valid = 1'b0;
    end else begin : gReg
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  rdValid_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dout_q    <= '0;
                rdValid_q <= 1'b0;
            end else begin
                rdValid_q <= renAcc;
                if (renAcc) dout_q <= mem_q[rdPtr_q];
            end
        end

        assign data_out = dout_q;
        assign rd_valid = rdValid_q;
    end

endmodule

// File: tb/tb_fifo_sc_prog.sv
// Directed bench for fifo_sc_prog: one FWFT and one registered-output instance share the same stimulus.
module tb_fifo_sc_prog;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] dataIn;
    logic        wen, ren, clrErr;

    logic [15:0] aData, bData;
    logic        aValid, bValid;
    logic [4:0]  aCount, bCount;
    logic        aEmpty, aFull, aAe, aAf, aOvf, aUnf;
    logic        bEmpty, bFull, bAe, bAf, bOvf, bUnf;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    fifo_sc_prog #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .AF_THRESH(12), .AE_THRESH(4), .FWFT(1'b1)) dutFwft (
        .clk(clk), .reset(reset), .data_in(dataIn), .wen(wen), .ren(ren), .clr_err(clrErr),
        .data_out(aData), .rd_valid(aValid), .count(aCount), .empty(aEmpty), .full(aFull),
        .almost_empty(aAe), .almost_full(aAf), .overflow(aOvf), .underflow(aUnf)
    );

    fifo_sc_prog #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .AF_THRESH(12), .AE_THRESH(4), .FWFT(1'b0)) dutReg (
        .clk(clk), .reset(reset), .data_in(dataIn), .wen(wen), .ren(ren), .clr_err(clrErr),
        .data_out(bData), .rd_valid(bValid), .count(bCount), .empty(bEmpty), .full(bFull),
        .almost_empty(bAe), .almost_full(bAf), .overflow(bOvf), .underflow(bUnf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        dataIn = '0;
        wen    = 1'b0;
        ren    = 1'b0;
        clrErr = 1'b0;
        #12;
        reset = 1'b0;
        #1;

        checkOutput("rst_count", aCount, 0);
        checkOutput("rst_empty", aEmpty, 1);
        checkOutput("rst_full", aFull, 0);
        checkOutput("rst_ae", aAe, 1);
        checkOutput("rst_af", aAf, 0);
        checkOutput("rst_ovf", aOvf, 0);
        checkOutput("rst_unf", aUnf, 0);
        checkOutput("rst_b_valid", bValid, 0);
        checkOutput("rst_b_data", bData, 0);

        // Fill to full, watching almost_full/almost_empty thresholds.
        for (int i = 0; i < 16; i++) begin
            wen = 1'b1;
            dataIn = 16'(i + 1);
            applyStimulus();
            checkOutput("fill_count", aCount, i + 1);
            checkOutput("fill_af", aAf, (i + 1 >= 12) ? 1 : 0);
            checkOutput("fill_ae", aAe, (i + 1 <= 4) ? 1 : 0);
            checkOutput("fill_full", aFull, (i + 1 == 16) ? 1 : 0);
        end
        checkOutput("fill_ovf", aOvf, 0);
        dataIn = 16'h0011;
        applyStimulus();
        wen = 1'b0;
        checkOutput("ovf_set", aOvf, 1);
        checkOutput("ovf_count", aCount, 16);

        // Drain: FWFT head before each read, registered output after it.
        for (int i = 0; i < 16; i++) begin
            checkOutput("drain_a_data", aData, i + 1);
            ren = 1'b1;
            applyStimulus();
            checkOutput("drain_b_data", bData, i + 1);
            checkOutput("drain_b_valid", bValid, 1);
        end
        checkOutput("drain_empty", aEmpty, 1);
        applyStimulus();
        ren = 1'b0;
        checkOutput("unf_set", aUnf, 1);
        checkOutput("unf_count", aCount, 0);
        checkOutput("unf_b_valid", bValid, 0);
        checkOutput("unf_b_hold", bData, 16'h0010);
        clrErr = 1'b1;
        applyStimulus();
        clrErr = 1'b0;
        checkOutput("clr_ovf", aOvf, 0);
        checkOutput("clr_unf", aUnf, 0);

        // Steady streaming at count 8 across pointer wrap.
        for (int k = 0; k < 8; k++) begin
            wen = 1'b1;
            dataIn = 16'(16'h0100 + k);
            applyStimulus();
        end
        for (int j = 0; j < 40; j++) begin
            wen = 1'b1;
            ren = 1'b1;
            dataIn = 16'(16'h0108 + j);
            checkOutput("stream_head", aData, 16'h0100 + j);
            applyStimulus();
            checkOutput("stream_count", aCount, 8);
            checkOutput("stream_b_data", bData, 16'h0100 + j);
        end
        wen = 1'b0;
        checkOutput("stream_ovf", aOvf, 0);
        checkOutput("stream_unf", aUnf, 0);
        for (int k = 0; k < 8; k++) begin
            checkOutput("stream_tail", aData, 16'h0128 + k);
            ren = 1'b1;
            applyStimulus();
        end
        ren = 1'b0;
        checkOutput("stream_empty", aEmpty, 1);

        // Registered read path: one-cycle latency, single-cycle rd_valid.
        wen = 1'b1;
        dataIn = 16'hABCD;
        applyStimulus();
        wen = 1'b0;
        ren = 1'b1;
        applyStimulus();
        ren = 1'b0;
        checkOutput("reg_data", bData, 16'hABCD);
        checkOutput("reg_valid", bValid, 1);
        applyStimulus();
        checkOutput("reg_valid_drop", bValid, 0);
        checkOutput("reg_data_hold", bData, 16'hABCD);

        // Simultaneous read and write while empty.
        wen = 1'b1;
        ren = 1'b1;
        dataIn = 16'h1234;
        applyStimulus();
        wen = 1'b0;
        ren = 1'b0;
        checkOutput("rw_empty_count", aCount, 1);
        checkOutput("rw_empty_unf", aUnf, 1);
        checkOutput("rw_empty_data", aData, 16'h1234);
        checkOutput("rw_empty_b_valid", bValid, 0);
        clrErr = 1'b1;
        applyStimulus();
        clrErr = 1'b0;
        checkOutput("rw_empty_clr", aUnf, 0);
        checkOutput("rw_empty_keep", aCount, 1);
        ren = 1'b1;
        applyStimulus();
        applyStimulus();
        ren = 1'b0;
        checkOutput("pre_rst_unf", aUnf, 1);

        // Fill to 10 then reset asynchronously between edges.
        for (int k = 0; k < 10; k++) begin
            wen = 1'b1;
            dataIn = 16'(16'h0200 + k);
            applyStimulus();
        end
        wen = 1'b0;
        checkOutput("pre_rst_count", aCount, 10);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("arst_count", aCount, 0);
        checkOutput("arst_empty", aEmpty, 1);
        checkOutput("arst_ovf", aOvf, 0);
        checkOutput("arst_unf", aUnf, 0);
        reset = 1'b0;
        wen = 1'b1;
        dataIn = 16'h5A5A;
        applyStimulus();
        wen = 1'b0;
        checkOutput("post_rst_count", aCount, 1);
        checkOutput("post_rst_data", aData, 16'h5A5A);
        ren = 1'b1;
        applyStimulus();
        ren = 1'b0;
        checkOutput("post_rst_b_data", bData, 16'h5A5A);
        checkOutput("post_rst_empty", aEmpty, 1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
